// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. Inputs are captured into a pending buffer on load and
// promoted to the active buffer only at frame boundaries, so a frame never
// shows a mix of old and new values. Segments, decimal point and anodes are
// all active low, and every output is registered.

module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter bit HEX_EN     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_wrap;
    logic             frame_end;

    // Pending (written by load) and active (displayed) buffers
    logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q,     act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q,  act_blank_q;
    logic                    pend_lz_q,     act_lz_q;

    // Per-digit darkness and the digit currently being scanned
    logic [NUM_DIGITS-1:0] dark_vec;
    logic [3:0]            digit_code;
    logic                  digit_supp;
    logic                  chain_clear;
    logic [3:0]            cur_code;
    logic                  cur_dark;
    logic                  cur_dp;
    logic                  ghost;

    // Registered outputs
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q;

    // Active-low gfedcba glyphs; hex letters only when HEX_EN is set.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = HEX_EN ? 7'b0001000 : 7'h7F;
            4'hB:    g = HEX_EN ? 7'b0000011 : 7'h7F;
            4'hC:    g = HEX_EN ? 7'b1000110 : 7'h7F;
            4'hD:    g = HEX_EN ? 7'b0100001 : 7'h7F;
            4'hE:    g = HEX_EN ? 7'b0000110 : 7'h7F;
            default: g = HEX_EN ? 7'b0001110 : 7'h7F;
        endcase
        return g;
    endfunction

    // Next scan position: slot counter wraps, digit index advances on wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        slot_wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Darkness per digit; zero suppression walks from the most significant
    // digit down and stops at the first digit that is neither blank nor a
    // suppressed zero. Digit 0 is never suppressed.
    always_comb begin
        dark_vec    = '0;
        digit_code  = '0;
        digit_supp  = 1'b0;
        chain_clear = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit_code  = act_digits_q[4*i +: 4];
            digit_supp  = act_lz_q && (digit_code == 4'd0) && (i > 0) && chain_clear;
            dark_vec[i] = act_blank_q[i] || (!HEX_EN && (digit_code >= 4'd10)) || digit_supp;
            chain_clear = chain_clear && (act_blank_q[i] || digit_supp);
        end
    end

    // Select the scanned digit and form the next output values.
    always_comb begin
        cur_code = '0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = act_digits_q[4*i +: 4];
                cur_dark = dark_vec[i];
                cur_dp   = act_dp_q[i] && !act_blank_q[i];
            end
        end
        // Segments and dp are also held dark while anodes are off so no
        // stale glyph bleeds into the next digit.
        ghost = (int'(cnt_q) < BLANK_CYC);
        seg_d = (ghost || cur_dark) ? 7'h7F : glyph(cur_code);
        dp_d  = !(cur_dp && !ghost);
        an_d  = ghost ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end

    // Scan counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Double buffer: load fills pending; the frame boundary commits to active,
    // taking a coincident load directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffers are reset to a blank display because the first frame must be dark.
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_lz_q     <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            act_lz_q      <= 1'b0;
        end else begin
            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp_in;
                pend_blank_q  <= blank_in;
                pend_lz_q     <= lz_en;
            end
            if (frame_end) begin
                act_digits_q <= load ? digits   : pend_digits_q;
                act_dp_q     <= load ? dp_in    : pend_dp_q;
                act_blank_q  <= load ? blank_in : pend_blank_q;
                act_lz_q     <= load ? lz_en    : pend_lz_q;
            end
        end
    end

    // Output registers: one cycle behind the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits. Generalises the single-digit BCD decoder to NUM_DIGITS digits with optional hex glyphs, per-digit decimal point and blanking, leading-zero suppression, inter-digit ghost blanking, and tear-free double-buffered updates. Sits between the player's display-formatting logic (track/time counters) and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8).
SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+1).
BLANK_CYC, 500, cycles at the start of each slot with all anodes off (0 disables ghost blanking).
HEX_EN, 0, 1 = codes 10..15 render A,b,C,d,E,F; 0 = codes 10..15 render blank.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits  in  4*NUM_DIGITS  packed codes; digit i = digits[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
blank_in  in  NUM_DIGITS  force digit dark (1 = blank)
lz_en  in  1  leading-zero suppression enable
load  in  1  one-cycle strobe capturing digits/dp_in/blank_in/lz_en into the pending buffer
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp  out  1  decimal point, active low
an  out  NUM_DIGITS  anode enables, active low, at most one low at any time
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous on rst_n low and released synchronously with clk: slot counter=0, digit index=0, pending and active buffers cleared with blank mask all ones; seg=7'h7F, dp=1, an=all ones, frame_tick=0.
- Slot counter counts 0..SCAN_DIV-1 and wraps; on wrap the digit index advances 0,1,..,NUM_DIGITS-1,0.
- Frame boundary: the cycle in which the counter wraps and the index is NUM_DIGITS-1. On that cycle the pending buffer is copied into the active buffer and frame_tick is asserted for exactly one cycle.
- load captures inputs into pending only; the display never changes mid-frame. load coincident with the boundary: the newly loaded values are committed directly (load wins). Multiple loads within a frame: last one wins.
- Glyph table, active low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. With HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Digit i is dark (seg=7'h7F) if any of the following holds: blank_in[i]=1; code>=10 and HEX_EN=0; or lz_en=1, the code is 0, i>0, and every higher digit j>i is either blank or a suppressed zero. Digit 0 is never zero-suppressed. dp follows dp_in[i] independently of suppression, but is dark when blank_in[i]=1.
- Ghost blanking: while the counter < BLANK_CYC, an=all ones. Otherwise an has only bit [index] low.
- Outputs seg, dp, an and frame_tick are registered: each reflects the counter/index state of the previous cycle, giving 1 cycle of latency.
- Asserting rst_n low mid-frame returns all outputs to reset values immediately, independent of clk. Pending data is lost.

Test Plan:
NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, HEX_EN=0.
1. Reset release, no load -> an=4'hF and seg=7'h7F throughout the first frame; frame_tick pulses every 32 cycles.
2. Load digits=16'h1234, dp_in=4'b0100, blank_in=0 -> from the next frame, each slot shows an=1110/1101/1011/0111 with seg=0011001/0110000/0100100/1111001 respectively. dp=0 only while an=1011. an=4'hF for the first 2 cycles of each slot.
3. Load digits=16'h0070 with lz_en=1 -> digits 3 and 2 dark, digit 1 shows 1111000, digit 0 shows 1000000. The same load with lz_en=0 -> digits 3 and 2 show 1000000.
4. Load 16'h5555 mid-frame, then 16'h6666 two cycles later -> the current frame is unchanged; the next frame shows 0000010 on all digits. A load coincident with frame_tick is committed at that same boundary.
5. Digit code 4'hB with HEX_EN=0 -> that digit is dark. Rerun with HEX_EN=1 -> seg=0000011.
6. Pull rst_n low mid-slot between clock edges -> seg=7'h7F, an=4'hF and dp=1 before the next clk edge. After release, the display stays blank until a new load is committed at a frame boundary.
